ramsdp_rdstream: RTL

RAMSDP_RDSTREAM -- requirements
Module: ramsdp_rdstream

---
 rtl/ramsdp_rdstream_if.sv | 28 ++
 rtl/ramsdp_rdstream.sv | 97 +++++++++
 2 files changed

// File: rtl/ramsdp_rdstream_if.sv
// Bundles the burst-control, memory read-port and output-stream signals of ramsdp_rdstream.
interface ramsdp_rdstream_if #(
    parameter int DW = 32,
    parameter int AW = 6
);
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   len;
    logic          busy;
    logic          done;
    logic          ram_en_b;
    logic [AW-1:0] ram_addr_b;
    logic [DW-1:0] ram_dout_b;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;

    modport master (
        output start, base_addr, len, ram_dout_b, out_ready,
        input  busy, done, ram_en_b, ram_addr_b, out_valid, out_data, out_last
    );

    modport slave (
        input  start, base_addr, len, ram_dout_b, out_ready,
        output busy, done, ram_en_b, ram_addr_b, out_valid, out_data, out_last
    );
endinterface

// File: rtl/ramsdp_rdstream.sv
// Streams a len-word burst from a simple-dual-port RAM read port into a valid/ready stream.
// out_valid follows the first read by 2 cycles; reads stall while FIFO words plus the in-flight read reach 3.
module ramsdp_rdstream #(
    parameter int DW = 32,
    parameter int AW = 6
) (
    input logic               clk,
    input logic               rst,
    ramsdp_rdstream_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] addr;
    logic [AW:0]   remain;
    logic          pend, pend_last;
    logic          done_q;
    logic [DW-1:0] fifo_dat [3];
    logic [2:0]    fifo_last;
    logic [1:0]    rd_ptr, wr_ptr, count;
    logic          accept, issue, push, pop, final_hs, last_issue;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Issue decision uses only registered state, so out_ready never reaches the RAM port.
    assign accept     = (state == IDLE) && bus.start && (bus.len != '0);
    assign issue      = (state == ISSUE) && ((3'(count) + 3'(pend)) < 3'd3);
    assign last_issue = issue && (remain == (AW+1)'(1));
    assign push       = pend;
    assign pop        = (count != 2'd0) && bus.out_ready;
    assign final_hs   = pop && fifo_last[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)     state_nxt = ISSUE;
            ISSUE:   if (last_issue) state_nxt = DRAIN;
            DRAIN:   if (final_hs)   state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy       = (state != IDLE);
        bus.done       = done_q;
        bus.ram_en_b   = issue;
        bus.ram_addr_b = addr;
        bus.out_valid  = (count != 2'd0);
        bus.out_data   = fifo_dat[rd_ptr];
        bus.out_last   = (count != 2'd0) && fifo_last[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr      <= '0;
            remain    <= '0;
            pend      <= 1'b0;
            pend_last <= 1'b0;
            done_q    <= 1'b0;
            rd_ptr    <= 2'd0;
            wr_ptr    <= 2'd0;
            count     <= 2'd0;
            fifo_last <= 3'b000;
            for (int i = 0; i < 3; i++) fifo_dat[i] <= '0;
        end else begin
            done_q    <= final_hs;
            pend      <= issue;
            pend_last <= last_issue;
            if (accept) begin
                addr   <= bus.base_addr;
                remain <= bus.len;
            end else if (issue) begin
                addr   <= addr + 1'b1;
                remain <= remain - 1'b1;
            end
            // RAM data is valid in the cycle after issue; the last-word tag travels with it.
            if (push) begin
                fifo_dat[wr_ptr]  <= bus.ram_dout_b;
                fifo_last[wr_ptr] <= pend_last;
                wr_ptr            <= ptr_inc(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end
endmodule
